traffic_light_ctrl: RTL and testbench

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_light_ctrl.sv | 128 ++++++++++++
 tb/tb_traffic_light_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Traffic light sequencer for a main/side crossing with an optional pedestrian phase.
// Phase durations are counted in timeout pulses from an external time-unit counter.
module traffic_light_ctrl #(
  parameter int unsigned GREEN_UNITS  = 3,
  parameter int unsigned YELLOW_UNITS = 1,
  parameter int unsigned RED_UNITS    = 1,
  parameter int unsigned WALK_UNITS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timeout,
  input  logic       ped_req,
  input  logic       hold,
  output logic       count_en,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    PED_WALK    = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_B   = 3'd6
  } state_e;

  localparam logic [3:0] GREEN_LAST  = 4'(GREEN_UNITS - 1);
  localparam logic [3:0] YELLOW_LAST = 4'(YELLOW_UNITS - 1);
  localparam logic [3:0] RED_LAST    = 4'(RED_UNITS - 1);
  localparam logic [3:0] WALK_LAST   = 4'(WALK_UNITS - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_e     state_q, state_d;
  state_e     next_phase;
  logic [3:0] unit_q, unit_d;
  logic [3:0] last_unit;
  logic       illegal_state;
  logic       ped_pending_q, ped_pending_d;
  logic       ped_prev_q;
  logic       count_en_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= MAIN_GREEN;
      unit_q        <= '0;
      ped_pending_q <= 1'b0;
      ped_prev_q    <= 1'b0;
      count_en_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      unit_q        <= unit_d;
      ped_pending_q <= ped_pending_d;
      ped_prev_q    <= ped_req;
      count_en_q    <= !hold;
    end
  end

  // Duration and successor of the phase currently being shown.
  always_comb begin
    last_unit     = RED_LAST;
    next_phase    = MAIN_GREEN;
    illegal_state = 1'b0;
    case (state_q)
      MAIN_GREEN:  begin last_unit = GREEN_LAST;  next_phase = MAIN_YELLOW; end
      MAIN_YELLOW: begin last_unit = YELLOW_LAST; next_phase = ALL_RED_A;   end
      ALL_RED_A:   begin
        last_unit  = RED_LAST;
        next_phase = ped_pending_q ? PED_WALK : SIDE_GREEN;
      end
      PED_WALK:    begin last_unit = WALK_LAST;   next_phase = SIDE_GREEN;  end
      SIDE_GREEN:  begin last_unit = GREEN_LAST;  next_phase = SIDE_YELLOW; end
      SIDE_YELLOW: begin last_unit = YELLOW_LAST; next_phase = ALL_RED_B;   end
      ALL_RED_B:   begin last_unit = RED_LAST;    next_phase = MAIN_GREEN;  end
      default:     illegal_state = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    unit_d        = unit_q;
    ped_pending_d = ped_pending_q;

    // Button edges latch even while held; only the PED_WALK entry clears them.
    if (ped_req && !ped_prev_q && (state_q != PED_WALK)) begin
      ped_pending_d = 1'b1;
    end

    if (illegal_state) begin
      state_d = MAIN_GREEN;
      unit_d  = '0;
    end else if (timeout && !hold) begin
      if (unit_q == last_unit) begin
        state_d = next_phase;
        unit_d  = '0;
        if (next_phase == PED_WALK) begin
          ped_pending_d = 1'b0;
        end
      end else begin
        unit_d = unit_q + 4'd1;
      end
    end
  end

  always_comb begin
    main_light = LAMP_RED;
    side_light = LAMP_RED;
    walk       = 1'b0;
    case (state_q)
      MAIN_GREEN:  main_light = LAMP_GREEN;
      MAIN_YELLOW: main_light = LAMP_YELLOW;
      PED_WALK:    walk       = 1'b1;
      SIDE_GREEN:  side_light = LAMP_GREEN;
      SIDE_YELLOW: side_light = LAMP_YELLOW;
      default:     ;
    endcase
  end

  assign count_en = count_en_q;
  assign state    = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a pulse-countdown model of the light sequence.
module tb_traffic_light_ctrl;

  logic       clk;
  logic       rst;
  logic       timeout;
  logic       ped_req;
  logic       hold;
  logic       count_en;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase number, pulses left in phase, pending request.
  int m_state;
  int m_left;
  bit m_ped;
  bit m_prev;
  bit m_cen;

  logic [2:0] obs_q[$];
  int         walk_seen;

  traffic_light_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .timeout    (timeout),
    .ped_req    (ped_req),
    .hold       (hold),
    .count_en   (count_en),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dur(int s);
    case (s)
      0, 4:    return 3;
      3:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int succ(int s, bit p);
    case (s)
      0:       return 1;
      1:       return 2;
      2:       return p ? 3 : 4;
      3:       return 4;
      4:       return 5;
      5:       return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] main_of(int s);
    case (s)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] side_of(int s);
    case (s)
      4:       return 3'b001;
      5:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance the model with the inputs as the DUT will see them, clock, then compare.
  task automatic tick();
    bit rise;
    bit enter_walk;
    if (!rst) begin
      m_state = 0;
      m_left  = dur(0);
      m_ped   = 0;
      m_prev  = 0;
      m_cen   = 0;
    end else begin
      rise       = ped_req && !m_prev && (m_state != 3);
      enter_walk = 0;
      if (timeout && !hold) begin
        m_left--;
        if (m_left == 0) begin
          m_state    = succ(m_state, m_ped);
          m_left     = dur(m_state);
          enter_walk = (m_state == 3);
        end
      end
      m_ped  = enter_walk ? 1'b0 : (m_ped | rise);
      m_prev = ped_req;
      m_cen  = !hold;
    end
    @(posedge clk);
    #1;
    check("state", 32'(state), 32'(m_state));
    check("main_light", 32'(main_light), 32'(main_of(m_state)));
    check("side_light", 32'(side_light), 32'(side_of(m_state)));
    check("walk", 32'(walk), 32'(m_state == 3));
    check("count_en", 32'(count_en), 32'(m_cen));
  endtask

  // n timeout pulses, one every gap cycles; records the state after each pulse.
  task automatic run_pulses(int n, int gap);
    obs_q.delete();
    walk_seen = 0;
    for (int i = 0; i < n; i++) begin
      timeout = 1'b0;
      for (int j = 1; j < gap; j++) tick();
      timeout = 1'b1;
      tick();
      timeout = 1'b0;
      obs_q.push_back(state);
      if (walk) walk_seen++;
    end
  endtask

  task automatic check_seq(string tag, int exp[12], int n);
    check({tag, "_len"}, 32'(obs_q.size()), 32'(n));
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      check(tag, 32'(obs_q[i]), 32'(exp[i]));
    end
  endtask

  task automatic ped_pulse();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
  endtask

  initial begin
    int n;
    rst     = 1'b0;
    timeout = 1'b0;
    ped_req = 1'b0;
    hold    = 1'b0;
    m_state = 0; m_left = 3; m_ped = 0; m_prev = 0; m_cen = 0;

    // Reset held for two cycles, then released.
    tick();
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_main", 32'(main_light), 32'b001);
    check("rst_side", 32'(side_light), 32'b100);
    check("rst_walk", 32'(walk), 32'd0);
    check("rst_count_en", 32'(count_en), 32'd0);
    rst = 1'b1;
    tick();
    check("count_en_after_release", 32'(count_en), 32'd1);

    // Normal cycle, one pulse per 10 cycles, no pedestrian.
    run_pulses(10, 10);
    check_seq("normal_seq", '{0, 0, 1, 2, 4, 4, 4, 5, 6, 0, 0, 0}, 10);

    // Pedestrian request during MAIN_GREEN, then a cycle that must skip the walk.
    ped_pulse();
    run_pulses(12, 4);
    check_seq("ped_seq", '{0, 0, 1, 2, 3, 3, 4, 4, 4, 5, 6, 0}, 12);
    check("walk_pulses", 32'(walk_seen), 32'd2);
    run_pulses(10, 2);
    check_seq("after_ped_seq", '{0, 0, 1, 2, 4, 4, 4, 5, 6, 0, 0, 0}, 10);

    // Hold after the first SIDE_GREEN pulse; a button press during hold still latches.
    run_pulses(6, 3);
    check("hold_pre_state", 32'(state), 32'd4);
    hold = 1'b1;
    tick();
    ped_pulse();
    run_pulses(5, 3);
    check("hold_state", 32'(state), 32'd4);
    check("hold_count_en", 32'(count_en), 32'd0);
    hold = 1'b0;
    tick();
    run_pulses(2, 3);
    check("hold_release_state", 32'(state), 32'd5);
    run_pulses(7, 2);
    check("held_ped_walk", 32'(state), 32'd3);
    run_pulses(7, 2);
    check("hold_cycle_end", 32'(state), 32'd0);

    // Reset in SIDE_YELLOW with a request pending: the request is dropped.
    run_pulses(5, 2);
    check("mid_pre_sg", 32'(state), 32'd4);
    run_pulses(3, 2);
    check("mid_pre_sy", 32'(state), 32'd5);
    ped_pulse();
    rst = 1'b0;
    tick();
    check("mid_rst_state", 32'(state), 32'd0);
    rst = 1'b1;
    run_pulses(5, 2);
    check("mid_rst_no_walk", 32'(state), 32'd4);
    run_pulses(5, 2);
    check("mid_rst_cycle_end", 32'(state), 32'd0);

    // Timeout stuck high: one unit per cycle.
    timeout = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (state == 3'd0 && n < 20);
    check("stuck_main_green_cycles", 32'(n), 32'd3);
    do begin
      tick();
      n++;
    end while (state != 3'd0 && n < 40);
    check("stuck_full_cycle", 32'(n), 32'd10);
    timeout = 1'b0;

    // Random traffic with occasional hold, button presses and resets.
    for (int i = 0; i < 3000; i++) begin
      timeout = ($urandom_range(0, 2) == 0);
      ped_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) hold = ~hold;
      rst = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
